// File: rtl/reset_tree_sequencer.sv
// Purpose : sequences a reset pulse through a fanout-limited register tree to
//           NUM_LEAVES pipeline resets and gates upstream traffic until the
//           leaves are out of reset; counts beats dropped while not ready.
// Latency : root asserts 1 cycle after rst/soft_rst_req, leaves LEVELS-1 cycles
//           later; ready rises RST_HOLD_CYCLES+LEVELS-1+GUARD_CYCLES cycles
//           after the request edge.
// Backpr. : no stall path; valid_in beats arriving while ready=0 are dropped
//           and counted (saturating), valid_out = valid_in & ready.
//
// Ports:
//   i_clk           clock
//   i_rst           synchronous active-high reset (priority over soft request)
//   i_soft_rst_req  level-sampled request to restart the reset sequence
//   i_valid_in      upstream beat valid
//   o_valid_out     i_valid_in gated by ready (combinational)
//   o_ready         registered, high while every leaf is released and settled
//   o_leaf_rst      active-high resets to the replicated pipelines
//   o_seq_done      one-cycle pulse on the first ready cycle of a sequence
//   o_drop_count    saturating count of valid_in beats seen while not ready

module reset_tree_sequencer #(
   parameter int NUM_LEAVES      = 8,
   parameter int FANOUT          = 2,
   parameter int RST_HOLD_CYCLES = 1,
   parameter int GUARD_CYCLES    = 0,
   parameter int DROP_W          = 16
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_soft_rst_req,
   input  logic                  i_valid_in,
   output logic                  o_valid_out,
   output logic                  o_ready,
   output logic [NUM_LEAVES-1:0] o_leaf_rst,
   output logic                  o_seq_done,
   output logic [DROP_W-1:0]     o_drop_count
);

   // ------------------------------------------------------------------
   // Tree geometry helpers (elaboration time only)
   // ------------------------------------------------------------------

   // Number of FANOUT-ary levels needed below the root to reach n leaves.
   function automatic int f_depth(input int n, input int f);
      int p;
      int d;
      p = 1;
      d = 0;
      for (int k = 0; k < 32; k++) begin
         if (p < n) begin
            p = p * f;
            d = d + 1;
         end
      end
      return d;
   endfunction

   // Register count of level l: min(f^l, n). Capped every step to avoid overflow.
   function automatic int f_lvl_size(input int l, input int n, input int f);
      int s;
      s = 1;
      for (int k = 0; k < 32; k++) begin
         if (k < l && s < n) begin
            s = s * f;
         end
      end
      return (s > n) ? n : s;
   endfunction

   // Bit offset of level l inside the flattened non-root tree vector
   // (level 1 starts at bit 0).
   function automatic int f_lvl_off(input int l, input int n, input int f);
      int o;
      o = 0;
      for (int k = 1; k < 32; k++) begin
         if (k < l) begin
            o = o + f_lvl_size(k, n, f);
         end
      end
      return o;
   endfunction

   localparam int LEVELS       = 1 + f_depth(NUM_LEAVES, FANOUT);
   localparam int TREE_BITS    = f_lvl_off(LEVELS, NUM_LEAVES, FANOUT);
   localparam int DRAIN_CYCLES = LEVELS - 1 + GUARD_CYCLES;

   // One counter serves both HOLD and DRAIN; size it for the longer phase.
   localparam int CNT_MAX = (RST_HOLD_CYCLES > DRAIN_CYCLES) ? RST_HOLD_CYCLES : DRAIN_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [CNT_W-1:0]  HOLD_LAST  = CNT_W'(RST_HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0]  DRAIN_LAST = CNT_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
   localparam logic [DROP_W-1:0] DROP_MAX   = '1;

   // ------------------------------------------------------------------
   // Sequencer FSM
   // ------------------------------------------------------------------

   typedef enum logic [1:0] {
      S_HOLD  = 2'd0,
      S_DRAIN = 2'd1,
      S_READY = 2'd2
   } state_t;

   state_t                  r_state;
   logic [CNT_W-1:0]        r_cnt;
   (* dont_merge *) logic   r_root;
   logic                    r_ready;
   logic                    r_seq_done;
   logic [DROP_W-1:0]       r_drop;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= S_HOLD;
         r_cnt      <= '0;
         r_root     <= 1'b1;
         r_ready    <= 1'b0;
         r_seq_done <= 1'b0;
      end else if (i_soft_rst_req) begin
         // A request in any state restarts the hold phase; when it lands in
         // HOLD or DRAIN the leaf pulse simply gets longer.
         r_state    <= S_HOLD;
         r_cnt      <= '0;
         r_root     <= 1'b1;
         r_ready    <= 1'b0;
         r_seq_done <= 1'b0;
      end else begin
         r_seq_done <= 1'b0;
         case (r_state)
            S_HOLD: begin
               if (r_cnt == HOLD_LAST) begin
                  r_cnt  <= '0;
                  r_root <= 1'b0;
                  // A single-level tree with no guard has nothing to drain.
                  if (DRAIN_CYCLES == 0) begin
                     r_state    <= S_READY;
                     r_ready    <= 1'b1;
                     r_seq_done <= 1'b1;
                  end else begin
                     r_state <= S_DRAIN;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DRAIN: begin
               // Waits for the deassertion edge to ripple to the leaves, plus guard.
               if (r_cnt == DRAIN_LAST) begin
                  r_cnt      <= '0;
                  r_state    <= S_READY;
                  r_ready    <= 1'b1;
                  r_seq_done <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_READY: begin
               r_ready <= 1'b1;
            end
            default: begin
               r_state <= S_HOLD;
               r_cnt   <= '0;
               r_root  <= 1'b1;
               r_ready <= 1'b0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Dropped-beat counter: only a hard reset clears it so software can read
   // losses across soft restarts.
   // ------------------------------------------------------------------

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_drop <= '0;
      end else if (i_valid_in && !r_ready && (r_drop != DROP_MAX)) begin
         r_drop <= r_drop + 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Reset distribution tree
   // ------------------------------------------------------------------

   if (LEVELS == 1) begin : g_flat
      assign o_leaf_rst = {NUM_LEAVES{r_root}};
   end else begin : g_tree
      // Non-root registers carry no reset: they flush from the root within
      // LEVELS-1 cycles, and keeping them reset-free keeps the reset net off
      // the tree itself. dont_merge keeps the fanout structure intact.
      logic [TREE_BITS-1:0]                   w_tree_d;
      (* dont_merge *) logic [TREE_BITS-1:0]  r_tree;

      for (genvar l = 1; l < LEVELS; l++) begin : g_lvl
         for (genvar j = 0; j < f_lvl_size(l, NUM_LEAVES, FANOUT); j++) begin : g_reg
            if (l == 1) begin : g_from_root
               assign w_tree_d[f_lvl_off(l, NUM_LEAVES, FANOUT) + j] = r_root;
            end else begin : g_from_parent
               assign w_tree_d[f_lvl_off(l, NUM_LEAVES, FANOUT) + j] =
                  r_tree[f_lvl_off(l - 1, NUM_LEAVES, FANOUT) + j / FANOUT];
            end
         end
      end

      always_ff @(posedge i_clk) begin
         r_tree <= w_tree_d;
      end

      assign o_leaf_rst = r_tree[f_lvl_off(LEVELS - 1, NUM_LEAVES, FANOUT) +: NUM_LEAVES];

      // When NUM_LEAVES is not a power of FANOUT, some registers on the level
      // above the leaves have no children; they are kept only for regularity.
      logic w_unused_tree;
      assign w_unused_tree = ^r_tree;
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------

   assign o_ready      = r_ready;
   assign o_seq_done   = r_seq_done;
   assign o_drop_count = r_drop;
   assign o_valid_out  = i_valid_in & r_ready;

endmodule
